run_controller: RTL
===================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter FETCH_STATE, default 4'h1: value of the processor State output that marks an instruction boundary.
REQ-002 Parameter MAX_CYCLES, default 16: maximum number of enabled cycles allowed per instruction before a fault is declared.
REQ-003 Port Clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-004 Port ResetN, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port StepStrobe, input, 1 bit: one-cycle pulse from the filtered key; requests one instruction.
REQ-006 Port RunStrobe, input, 1 bit: one-cycle pulse; requests free-running execution.
REQ-007 Port HaltStrobe, input, 1 bit: one-cycle pulse; requests a stop at the next instruction boundary.
REQ-008 Port BreakEn, input, 1 bit: enables breakpoint compare.
REQ-009 Port BreakAddr, input, 8 bits: breakpoint PC value.
REQ-010 Port PC, input, 8 bits: processor program counter.
REQ-011 Port State, input, 4 bits: processor FSM state.
REQ-012 Port ProcEn, output, 1 bit: processor clock enable; the processor advances one state per cycle while it is high.
REQ-013 Port Mode, output, 2 bits: encoding 0=IDLE, 1=STEP, 2=RUN, 3=BRK.
REQ-014 Port InstrCount, output, 16 bits: number of completed instructions.
REQ-015 Port BreakHit, output, 1 bit: high while in BRK.
REQ-016 Port Fault, output, 1 bit: sticky watchdog flag.

Function
REQ-017 FSM states: IDLE, STEP, RUN, BRK; Mode SHALL equal the current state encoding.
REQ-018 Internal counter Adv (width sufficient for MAX_CYCLES) SHALL count ProcEn-high cycles since the last entry into STEP/RUN or the last boundary; Boundary = (State==FETCH_STATE) && (Adv>=1).
REQ-019 In IDLE or BRK, ProcEn SHALL be 0.
REQ-020 In STEP or RUN, ProcEn SHALL be 1 except in a cycle where StopNow is true, where it SHALL be 0 (combinational).
REQ-021 StopNow SHALL be Boundary && (state==STEP || HaltPend || (BreakEn && PC==BreakAddr)).
REQ-022 IDLE->STEP on StepStrobe; IDLE->RUN on RunStrobe; if both are asserted, STEP wins.
REQ-023 BRK->RUN on RunStrobe; BRK->STEP on StepStrobe; BreakHit clears on exit.
REQ-024 STEP->IDLE on Boundary.
REQ-025 RUN->BRK on a Boundary with a break match; RUN->IDLE on a Boundary with HaltPend; if both, break wins.
REQ-026 HaltPend SHALL set on HaltStrobe in RUN and clear on leaving RUN.
REQ-027 HaltStrobe in IDLE, STEP or BRK SHALL move BRK->IDLE and otherwise be ignored.
REQ-028 HaltStrobe asserted in the same cycle as RunStrobe or StepStrobe SHALL win, with no transition out of IDLE/BRK into an execute state.
REQ-029 Step and Run strobes received while in STEP or RUN SHALL be ignored.
REQ-030 On each Boundary, Adv SHALL reset to 0 and InstrCount SHALL increment by 1, wrapping 16'hFFFF->16'h0000.
REQ-031 Because Adv=0 on entry, resuming from BRK at the breakpoint PC SHALL NOT re-trigger the breakpoint.
REQ-032 If Adv reaches MAX_CYCLES without a Boundary, the FSM SHALL go to IDLE, set Fault and drop ProcEn the same cycle.
REQ-033 Fault SHALL be cleared only by reset.

Reset
REQ-034 ResetN low SHALL immediately, independent of Clk, force IDLE, ProcEn=0, Adv=0, HaltPend=0, InstrCount=0, BreakHit=0, Fault=0.
REQ-035 Reset deassertion mid-STEP/RUN SHALL leave the block in IDLE, with no ProcEn pulse until a new strobe.

Verification
REQ-036 Step: processor model cycling 1->2->3->1, StepStrobe -> ProcEn high 3 cycles, low when State==1, Mode 1->0, InstrCount=1.
REQ-037 Breakpoint: BreakEn=1, BreakAddr=8'h05, RunStrobe -> stop with PC=05 at fetch, ProcEn=0 that cycle, Mode=3, BreakHit=1; a further RunStrobe runs past 05 without re-stopping and InstrCount keeps incrementing.
REQ-038 Halt: HaltStrobe mid-instruction in RUN -> ProcEn continues to the next fetch, then Mode=0; HaltStrobe together with RunStrobe in IDLE -> stays IDLE.
REQ-039 Watchdog: State held at 4'h2 after StepStrobe -> after 16 enabled cycles Fault=1, Mode=0, ProcEn=0.
REQ-040 Wrap and reset: InstrCount preloaded via 65535 steps, one more step -> InstrCount=0; ResetN pulsed low mid-RUN -> all outputs zero asynchronously.

Source files
------------

// File: rtl/run_controller.sv
// Run/step/breakpoint controller gating a processor clock enable.
// Tracks instruction boundaries, counts instructions and trips a watchdog on stuck instructions.
module run_controller #(
  parameter logic [3:0] FETCH_STATE = 4'h1,
  parameter int         MAX_CYCLES  = 16
) (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic        StepStrobe,
  input  logic        RunStrobe,
  input  logic        HaltStrobe,
  input  logic        BreakEn,
  input  logic [7:0]  BreakAddr,
  input  logic [7:0]  PC,
  input  logic [3:0]  State,
  output logic        ProcEn,
  output logic [1:0]  Mode,
  output logic [15:0] InstrCount,
  output logic        BreakHit,
  output logic        Fault
);

  localparam int ADV_W = $clog2(MAX_CYCLES + 1);
  localparam logic [ADV_W-1:0] ADV_MAX = ADV_W'(MAX_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STEP = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_BRK  = 2'd3;

  logic [1:0]       r_state;
  logic [ADV_W-1:0] r_adv;
  logic             r_halt_pend;
  logic [15:0]      r_instr_count;
  logic             r_fault;

  logic [1:0]       w_state_next;
  logic [ADV_W-1:0] w_adv_next;
  logic             w_halt_pend_next;
  logic             w_exec;
  logic             w_boundary;
  logic             w_brk_match;
  logic             w_stop_now;
  logic             w_watchdog;

  assign w_exec      = (r_state == S_STEP) || (r_state == S_RUN);
  // Adv>=1 keeps the fetch we resumed on from counting as a boundary.
  assign w_boundary  = w_exec && (State == FETCH_STATE) && (r_adv != '0);
  assign w_brk_match = BreakEn && (PC == BreakAddr);
  assign w_stop_now  = w_boundary &&
                       ((r_state == S_STEP) || r_halt_pend || w_brk_match);
  assign w_watchdog  = w_exec && !w_boundary && (r_adv >= ADV_MAX);

  assign ProcEn     = w_exec && !w_stop_now && !w_watchdog;
  assign Mode       = r_state;
  assign BreakHit   = (r_state == S_BRK);
  assign InstrCount = r_instr_count;
  assign Fault      = r_fault;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_BRK: begin
        // A halt strobe beats any simultaneous step/run request.
        if (HaltStrobe)      w_state_next = S_IDLE;
        else if (StepStrobe) w_state_next = S_STEP;
        else if (RunStrobe)  w_state_next = S_RUN;
      end
      S_STEP: begin
        if (w_boundary || w_watchdog) w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (w_boundary && w_brk_match)      w_state_next = S_BRK;
        else if (w_boundary && r_halt_pend) w_state_next = S_IDLE;
        else if (w_watchdog)                w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adv_next = r_adv;
    if (w_boundary || (w_state_next != r_state) || !w_exec)
      w_adv_next = '0;
    else if (ProcEn)
      w_adv_next = r_adv + ADV_W'(1);
  end

  assign w_halt_pend_next = (r_state == S_RUN) && (w_state_next == S_RUN) &&
                            (r_halt_pend || HaltStrobe);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state       <= S_IDLE;
      r_adv         <= '0;
      r_halt_pend   <= 1'b0;
      r_instr_count <= 16'h0000;
      r_fault       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_adv       <= w_adv_next;
      r_halt_pend <= w_halt_pend_next;
      if (w_boundary)
        r_instr_count <= r_instr_count + 16'h0001;
      if (w_watchdog)
        r_fault <= 1'b1;
    end
  end

endmodule
